// File: rtl/alu_hilo_divider.sv
// Iterative restoring divider for DIV/DIVU: LO <= quotient, HI <= remainder.
// One quotient bit per cycle, then a sign-fixup cycle, then a one-cycle done pulse.
module alu_hilo_divider #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              signed_op,
    input  logic              cancel,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_zero
);

    localparam int CNT_W = $clog2(DATA_W);

    // Handshake: start is taken only in IDLE/DONE (sampled with operands); while busy=1
    // start is dropped; done pulses one cycle with results, which then hold until the
    // next accepted start. cancel aborts ITER/FIX without done and without touching results.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              accept;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] quo_sh;
    logic [DATA_W-1:0] part;
    logic [DATA_W-1:0] dvsr_mag;
    logic [DATA_W-1:0] dvd_raw;
    logic              q_neg;
    logic              r_neg;
    logic              zero_div;

    logic [DATA_W:0]   part_sh;
    logic [DATA_W:0]   trial;
    logic              borrow;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic              is_signed);
        return (is_signed && v[DATA_W-1]) ? -v : v;
    endfunction

    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (cancel)                   state_nxt = IDLE;
                else if (cnt == '0)           state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = cancel ? IDLE : DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = accept ? ITER : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Restoring step: shift next dividend bit into the partial remainder and trial-subtract.
    // The partial remainder is always below the divisor, so bit DATA_W of the difference
    // is set exactly when the subtraction borrows.
    always_comb begin
        part_sh = {part, quo_sh[DATA_W-1]};
        trial   = part_sh - {1'b0, dvsr_mag};
        borrow  = trial[DATA_W];
    end

    always_comb begin
        q_fix = q_neg ? -quo_sh : quo_sh;
        r_fix = r_neg ? -part : part;
        if (zero_div) begin
            q_fix = '1;
            r_fix = dvd_raw;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            quo_sh   <= '0;
            part     <= '0;
            dvsr_mag <= '0;
            dvd_raw  <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            zero_div <= 1'b0;
        end else if (accept) begin
            cnt      <= CNT_W'(DATA_W - 1);
            quo_sh   <= magnitude(dividend, signed_op);
            part     <= '0;
            dvsr_mag <= magnitude(divisor, signed_op);
            dvd_raw  <= dividend;
            q_neg    <= signed_op && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            r_neg    <= signed_op && dividend[DATA_W-1];
            zero_div <= (divisor == '0);
        end else if (state == ITER) begin
            part     <= borrow ? part_sh[DATA_W-1:0] : trial[DATA_W-1:0];
            quo_sh   <= {quo_sh[DATA_W-2:0], ~borrow};
            cnt      <= cnt - CNT_W'(1);
        end
    end

    // Results change only on the edge into DONE; a cancel in FIX leaves them untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if ((state == FIX) && !cancel) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            div_zero  <= zero_div;
        end
    end

endmodule

// File: tb/tb_alu_hilo_divider.sv
// Directed plus random bench for alu_hilo_divider at DATA_W=4, with an expected-result queue.
module tb_alu_hilo_divider;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic         cancel = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    logic [2*W:0] exp_q[$];
    logic [2*W:0] last_res = '0;
    int           vectors = 0;
    int           miscompares = 0;

    alu_hilo_divider #(.DATA_W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .cancel    (cancel),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result packed as {div_zero, remainder, quotient}.
    function automatic logic [2*W:0] model(input logic sop, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int qi;
        int ri;
        logic [W-1:0] qv;
        logic [W-1:0] rv;
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        if (sop) begin
            qi = int'($signed(a)) / int'($signed(b));
            ri = int'($signed(a)) % int'($signed(b));
        end else begin
            qi = int'(a) / int'(b);
            ri = int'(a) % int'(b);
        end
        qv = qi[W-1:0];
        rv = ri[W-1:0];
        return {1'b0, rv, qv};
    endfunction

    task automatic check_outputs(input string tag, input logic [2*W:0] e);
        check({tag, ".quotient"}, 8'(quotient), 8'(e[W-1:0]));
        check({tag, ".remainder"}, 8'(remainder), 8'(e[2*W-1:W]));
        check({tag, ".div_zero"}, 8'(div_zero), 8'(e[2*W]));
    endtask

    // kind: 0 plain, 1 stray start at poke_c, 2 cancel at poke_c, 3 reset at poke_c.
    // Returns in the DONE cycle (kinds 0/1) so an immediate next call is back-to-back.
    task automatic run_div(input string tag, input logic sop, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int kind, input int poke_c);
        logic [2*W:0] e;
        logic         eb;
        logic         ed;
        start     = 1'b1;
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        exp_q.push_back(model(sop, a, b));
        tick();
        start = 1'b0;
        for (int c = 1; c <= W + 4; c++) begin
            if (kind == 3 && c == poke_c) begin
                reset = 1'b1;
                #1;
                check({tag, ".rst_busy"}, 8'(busy), 8'h0);
                check({tag, ".rst_done"}, 8'(done), 8'h0);
                check_outputs({tag, ".rst"}, '0);
                tick();
                reset = 1'b0;
                void'(exp_q.pop_back());
                last_res = '0;
                return;
            end
            eb = (kind == 2 && c > poke_c) ? 1'b0 : (c <= W + 1);
            ed = (kind != 2) && (c == W + 2);
            check({tag, ".busy"}, 8'(busy), 8'(eb));
            check({tag, ".done"}, 8'(done), 8'(ed));
            if (ed) begin
                e = exp_q.pop_front();
                check_outputs(tag, e);
                last_res = e;
                return;
            end
            if (kind == 2 && c > poke_c) check_outputs({tag, ".held"}, last_res);
            if (c == poke_c && kind == 1) begin
                start     = 1'b1;
                signed_op = 1'b0;
                dividend  = 4'h7;
                divisor   = 4'h1;
            end
            if (c == poke_c && kind == 2) cancel = 1'b1;
            tick();
            start  = 1'b0;
            cancel = 1'b0;
        end
        if (kind == 2) void'(exp_q.pop_back());
    endtask

    initial begin
        #3;
        check("in_reset.busy", 8'(busy), 8'h0);
        check("in_reset.done", 8'(done), 8'h0);
        check_outputs("in_reset", '0);
        tick();
        reset = 1'b0;
        tick();
        check("post_reset.busy", 8'(busy), 8'h0);
        check("post_reset.done", 8'(done), 8'h0);
        check_outputs("post_reset", '0);

        run_div("divu_7_3", 1'b0, 4'h7, 4'h3, 0, 0);
        tick();
        run_div("div_m7_2", 1'b1, 4'h9, 4'h2, 0, 0);
        run_div("div_7_m2", 1'b1, 4'h7, 4'hE, 0, 0);
        run_div("divu_5_0", 1'b0, 4'h5, 4'h0, 0, 0);
        run_div("divu_f_f", 1'b0, 4'hF, 4'hF, 0, 0);
        run_div("div_ovf", 1'b1, 4'h8, 4'hF, 0, 0);
        run_div("div_m3_0", 1'b1, 4'hD, 4'h0, 0, 0);
        tick();

        run_div("ign_start", 1'b0, 4'hA, 4'h3, 1, 2);
        tick();
        run_div("cancel", 1'b0, 4'hA, 4'h3, 2, 3);
        run_div("div_m8_3", 1'b1, 4'h8, 4'h3, 0, 0);
        tick();
        run_div("reset_mid", 1'b0, 4'hA, 4'h3, 3, 3);
        tick();

        run_div("b2b_first", 1'b0, 4'hA, 4'h3, 0, 0);
        run_div("b2b_second", 1'b0, 4'hA, 4'h3, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run_div("random", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 0, 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        tick();
        check("final_idle.busy", 8'(busy), 8'h0);
        check("queue_empty", 8'(exp_q.size()), 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_hilo_divider.md
Name: alu_hilo_divider

Overview:
- Iterative multi-cycle divider feeding the HI/LO pair. It is the inverse-direction companion to the HI/LO multiply path: multiply writes {HI,LO} from two operands, while this block produces LO=quotient and HI=remainder for DIV/DIVU.
- It sits beside the HI/LO ALU in the execute stage. The pipeline stalls on busy and commits quotient/remainder to LO/HI on done.

Parameters:
- DATA_W, 32, operand/result width in bits (bench uses 4); must be ≥2.
- CNT_W, $clog2(DATA_W), iteration counter width; derived, not overridden.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to divide; accepted only in IDLE or DONE.
- signed_op  in  1  1=DIV (two's complement), 0=DIVU; sampled with start.
- cancel  in  1  synchronous flush of an in-flight divide.
- dividend  in  DATA_W  numerator; sampled with start.
- divisor  in  DATA_W  denominator; sampled with start.
- busy  out  1  divide in progress; pipeline must stall HI/LO readers.
- done  out  1  single-cycle pulse; quotient/remainder valid for commit.
- quotient  out  DATA_W  to LO; held until next accepted start.
- remainder  out  DATA_W  to HI; held until next accepted start.
- div_zero  out  1  divisor was zero for the result being presented.

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, div_zero=0; quotient, remainder=0; internal regs cleared. Reset mid-divide aborts with no done.
- States: IDLE, ITER, FIX, DONE.
  - IDLE: on start, latch operands and sign info, go to ITER with count=DATA_W-1.
  - ITER: one restoring step per cycle; when count==0, go to FIX.
  - FIX: apply sign correction, register outputs, go to DONE.
  - DONE: done=1 for exactly this cycle. start here is accepted, same as IDLE, giving back-to-back operation; otherwise go to IDLE.
- Latency: if start is accepted in cycle 0, busy=1 in cycles 1..DATA_W+1, and done=1 with busy=0 in cycle DATA_W+2. Results update on the edge entering DONE.
- start while busy=1 is ignored; no queuing.
- Signed mode:
  - Divide magnitudes |dividend|, |divisor| as DATA_W-bit unsigned values.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - Invariant: dividend = quotient*divisor + remainder.
- Overflow (most-negative / -1): quotient = most-negative, remainder = 0, div_zero = 0. This falls out of the magnitude path; no special flag.
- Divisor zero (either mode): same latency; quotient = all ones, remainder = dividend (unmodified), div_zero = 1; sign fixup bypassed.
- Restoring step:
  - Partial remainder is DATA_W+1 bits: shift in the next dividend MSB, trial-subtract the divisor.
  - Quotient bit = not borrow; restore on borrow.
- cancel:
  - In ITER/FIX: go to IDLE next cycle; busy drops; no done; quotient/remainder/div_zero keep previous values.
  - In IDLE/DONE: ignored.
  - cancel and start in the same cycle in IDLE/DONE: start wins.
- div_zero is updated together with quotient/remainder, and is held until the next result.

Test Plan (DATA_W=4, ~1 cycle/clock, reset pulsed at start):
1. During reset and after release: busy=0, done=0, quotient=4'h0, remainder=4'h0, div_zero=0. Then DIVU 4'h7/4'h3 -> done in cycle 6 with quotient=4'h2, remainder=4'h1; busy high cycles 1–5.
2. DIV 4'h9(-7)/4'h2 -> quotient=4'hD(-3), remainder=4'hF(-1). DIV 4'h7/4'hE(-2) -> quotient=4'hD, remainder=4'h1.
3. DIVU 4'h5/4'h0 -> quotient=4'hF, remainder=4'h5, div_zero=1, done in cycle 6. Next DIVU 4'hF/4'hF -> quotient=4'h1, remainder=4'h0, div_zero=0.
4. DIV 4'h8(-8)/4'hF(-1) -> quotient=4'h8, remainder=4'h0, div_zero=0.
5. Start DIVU 4'hA/4'h3. Assert start with other operands in cycle 2 -> ignored; the original result quotient=4'h3, remainder=4'h1 arrives in cycle 6. Repeat with cancel in cycle 3 -> busy=0 from cycle 4, no done, outputs still 3/1. Repeat with reset in cycle 3 -> all outputs 0 immediately, no done.
6. Back-to-back: start DIVU 4'hA/4'h3 again in the DONE cycle of a prior divide -> busy next cycle, second done exactly 6 cycles later.
